wb_ram128_initiator: RTL and testbench

- Wishbone classic slave that drives a single-port RAM128-style macro port (EN0, WE0, Di0, A0, Do0) as the initiating side.
- Converts user-project Wishbone cycles into macro enable/write-strobe sequences and returns read data from Do0.
- Sits between the user-project Wishbone bus (wbs_*) and one RAM128 instance.
- Adds an address-window decode, programmable wait states and abort handling.

---
 rtl/wb_ram128_initiator_if.sv | 21 ++
 rtl/wb_ram128_initiator.sv | 87 ++++++++
 tb/tb_wb_ram128_initiator.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram128_initiator_if.sv
// Wishbone classic bus between the user-project master and the RAM128 initiator.
interface wb_ram128_initiator_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_ram128_initiator.sv
// Wishbone classic slave that sequences EN0/WE0 on a single-port RAM128 macro,
// with address-window decode, programmable wait states and abort handling.
module wb_ram128_initiator #(
  parameter int          ADDR_WIDTH  = 7,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FE00,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_ram128_initiator_if.slave  wbs,
  output logic                  ram_en0,
  output logic [3:0]            ram_we0,
  output logic [31:0]           ram_di0,
  output logic [ADDR_WIDTH-1:0] ram_a0,
  input  logic [31:0]           ram_do0
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic                  en_nx;
  logic [3:0]            we_nx;
  logic [31:0]           di_nx;
  logic [ADDR_WIDTH-1:0] a_nx;
  logic                  req, hit;

  assign req = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign hit = req & ((wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ram_en0 <= 1'b0;
      ram_we0 <= '0;
      ram_di0 <= '0;
      ram_a0  <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ram_en0 <= en_nx;
      ram_we0 <= we_nx;
      ram_di0 <= di_nx;
      ram_a0  <= a_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    en_nx    = ram_en0;
    we_nx    = ram_we0;
    di_nx    = ram_di0;
    a_nx     = ram_a0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          a_nx     = wbs.wbs_adr_i[ADDR_WIDTH+1:2];
          di_nx    = wbs.wbs_dat_i;
          we_nx    = wbs.wbs_we_i ? wbs.wbs_sel_i : 4'b0000;
          en_nx    = 1'b1;
          cnt_nx   = 4'(WAIT_STATES);
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        // Write strobe lives only in the first enabled cycle; later cycles re-read the word.
        we_nx = 4'b0000;
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          en_nx    = 1'b0;
          state_nx = req ? ACK : IDLE;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Do0 holds the word captured at the last enabled edge throughout the ACK cycle.
  assign wbs.wbs_ack_o = (state == ACK);
  assign wbs.wbs_dat_o = (state == ACK) ? ram_do0 : 32'h0;

endmodule

// File: tb/tb_wb_ram128_initiator.sv
// Randomized bench for wb_ram128_initiator: two instances (0 and 3 wait states),
// each driving a behavioural RAM128 macro, checked against a word-level memory model.
module tb_wb_ram128_initiator;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_FE00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0]       cyc_d, stb_d, we_d;
  logic [1:0][3:0]  sel_d;
  logic [1:0][31:0] adr_d, dat_d;
  logic [1:0]       ack_s;
  logic [1:0][31:0] rdat_s;
  logic [1:0]       en_s;
  logic [1:0][3:0]  we0_s;
  logic [1:0][31:0] di_s;
  logic [1:0][6:0]  a_s;
  logic [1:0][31:0] do_s;

  logic [31:0] mem     [2][128];
  logic [31:0] exp_mem [2][128];

  int checks   = 0;
  int failures = 0;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      wb_ram128_initiator_if bus();
      assign bus.wbs_cyc_i = cyc_d[g];
      assign bus.wbs_stb_i = stb_d[g];
      assign bus.wbs_we_i  = we_d[g];
      assign bus.wbs_sel_i = sel_d[g];
      assign bus.wbs_adr_i = adr_d[g];
      assign bus.wbs_dat_i = dat_d[g];
      assign ack_s[g]      = bus.wbs_ack_o;
      assign rdat_s[g]     = bus.wbs_dat_o;

      wb_ram128_initiator #(.WAIT_STATES((g == 0) ? 0 : 3)) u_dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus),
        .ram_en0  (en_s[g]),
        .ram_we0  (we0_s[g]),
        .ram_di0  (di_s[g]),
        .ram_a0   (a_s[g]),
        .ram_do0  (do_s[g])
      );
    end
  endgenerate

  // RAM128 macro: registered read, byte write enables, output forced to 0 when disabled.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (en_s[k]) begin
        do_s[k] <= mem[k][a_s[k]];
        for (int b = 0; b < 4; b++)
          if (we0_s[k][b]) mem[k][a_s[k]][b*8 +: 8] <= di_s[k][b*8 +: 8];
      end else begin
        do_s[k] <= 32'h0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bus transaction on instance k; abort_cyc>0 drops stb in that cycle.
  task automatic xfer(input int k, input bit we, input logic [3:0] sel,
                      input logic [31:0] adr, input logic [31:0] dat, input int abort_cyc);
    int w        = (k == 0) ? 0 : 3;
    bit hit      = ((adr & MASK) == BASE);
    int widx     = int'(adr[8:2]);
    int limit    = hit ? (w + 8) : 20;
    int en_cnt   = 0;
    int we_cnt   = 0;
    int ack_cyc  = -1;
    int acks     = 0;
    int bad_a    = 0;
    int leak     = 0;
    logic [3:0]  we_first = 4'h0;
    logic [31:0] rd = 32'h0;
    cyc_d[k] = 1'b1; stb_d[k] = 1'b1; we_d[k] = we;
    sel_d[k] = sel;  adr_d[k] = adr;  dat_d[k] = dat;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == abort_cyc) stb_d[k] = 1'b0;
      if (en_s[k]) begin
        en_cnt++;
        if (int'(a_s[k]) != widx) bad_a++;
      end
      if (we0_s[k] != 4'h0) begin
        we_cnt++;
        we_first = we0_s[k];
      end
      if (ack_s[k]) begin
        acks++;
        if (ack_cyc < 0) ack_cyc = c;
        rd = rdat_s[k];
        cyc_d[k] = 1'b0; stb_d[k] = 1'b0;
      end else if (rdat_s[k] != 32'h0) begin
        leak++;
      end
      if (ack_cyc > 0 && c == ack_cyc + 1) break;
    end
    cyc_d[k] = 1'b0; stb_d[k] = 1'b0;
    if (!hit) begin
      chk("miss_en_cycles", 32'(en_cnt), 32'd0);
      chk("miss_acks", 32'(acks), 32'd0);
    end else begin
      chk("en_cycles", 32'(en_cnt), 32'(w + 1));
      chk("addr_held", 32'(bad_a), 32'd0);
      chk("we_cycles", 32'(we_cnt), (we && sel != 4'h0) ? 32'd1 : 32'd0);
      if (we && sel != 4'h0) chk("we_value", {28'h0, we_first}, {28'h0, sel});
      chk("dat_zero_outside_ack", 32'(leak), 32'd0);
      if (abort_cyc > 0) begin
        chk("abort_acks", 32'(acks), 32'd0);
      end else begin
        chk("ack_cycle", 32'(ack_cyc), 32'(w + 2));
        chk("ack_count", 32'(acks), 32'd1);
        if (!we) chk("read_data", rd, exp_mem[k][widx]);
      end
      if (we)
        for (int b = 0; b < 4; b++)
          if (sel[b]) exp_mem[k][widx][b*8 +: 8] = dat[b*8 +: 8];
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_en"},  {31'h0, en_s[k]},  32'h0);
      chk({tag, "_we"},  {28'h0, we0_s[k]}, 32'h0);
      chk({tag, "_di"},  di_s[k],           32'h0);
      chk({tag, "_a"},   {25'h0, a_s[k]},   32'h0);
      chk({tag, "_ack"}, {31'h0, ack_s[k]}, 32'h0);
      chk({tag, "_dat"}, rdat_s[k],         32'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] adr, dat;
    int          acks, wes;
    rst = 1'b1;
    cyc_d = '0; stb_d = '0; we_d = '0; sel_d = '0; adr_d = '0; dat_d = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Fill both macros so every later read has a known expected word.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 128; i++)
        xfer(k, 1'b1, 4'hF, BASE + 32'(i * 4), $urandom, 0);

    // Directed sequence from the plan on the zero-wait instance.
    xfer(0, 1'b1, 4'hF,    32'h3000_0010, 32'hDEADBEEF, 0);
    xfer(0, 1'b0, 4'h0,    32'h3000_0010, 32'h0,        0);
    chk("plan_word4", exp_mem[0][4], 32'hDEADBEEF);
    xfer(0, 1'b1, 4'b0100, 32'h3000_0010, 32'h00AA0000, 0);
    xfer(0, 1'b0, 4'h0,    32'h3000_0010, 32'h0,        0);
    chk("plan_byte_merge", exp_mem[0][4], 32'hDEAABEEF);
    xfer(0, 1'b0, 4'h0,    32'h3000_0400, 32'h0,        0);
    xfer(0, 1'b1, 4'h0,    32'h3000_0020, 32'h12345678, 0);
    xfer(0, 1'b0, 4'h0,    32'h3000_0020, 32'h0,        0);

    // Wait-state instance: write, read, sel=0 write, miss.
    xfer(1, 1'b1, 4'hF, 32'h3000_01FC, 32'hCAFEF00D, 0);
    xfer(1, 1'b0, 4'h0, 32'h3000_01FC, 32'h0,        0);
    xfer(1, 1'b1, 4'h0, 32'h3000_01FC, 32'h0BADBAD0, 0);
    xfer(1, 1'b0, 4'h0, 32'h3000_01FC, 32'h0,        0);
    xfer(1, 1'b1, 4'hF, 32'h3000_0200, 32'h0,        0);

    // Aborts: stb dropped in cycle 1; the write still commits once, no ack.
    xfer(0, 1'b1, 4'hF, 32'h3000_0040, 32'hA5A5_0001, 1);
    xfer(0, 1'b0, 4'h0, 32'h3000_0040, 32'h0,         0);
    xfer(1, 1'b1, 4'h3, 32'h3000_0044, 32'h5A5A_0002, 1);
    xfer(1, 1'b0, 4'h0, 32'h3000_0044, 32'h0,         0);

    // Reset landing on the first ACCESS cycle of a write.
    cyc_d[0] = 1'b1; stb_d[0] = 1'b1; we_d[0] = 1'b1; sel_d[0] = 4'hF;
    adr_d[0] = 32'h3000_0080; dat_d[0] = 32'h7777_1234;
    @(negedge clk);
    chk("rst_we_cycle1", {28'h0, we0_s[0]}, 32'hF);
    rst = 1'b1; cyc_d[0] = 1'b0; stb_d[0] = 1'b0;
    @(negedge clk);
    chk_outputs_zero("mid_reset");
    rst = 1'b0;
    exp_mem[0][32] = 32'h7777_1234;
    acks = 0; wes = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_s[0]) acks++;
      if (we0_s[0] != 4'h0) wes++;
    end
    chk("rst_no_ack", 32'(acks), 32'd0);
    chk("rst_no_rewrite", 32'(wes), 32'd0);
    xfer(0, 1'b0, 4'h0, 32'h3000_0080, 32'h0, 0);

    // Randomized traffic, occasional misses and aborts.
    for (int n = 0; n < 200; n++) begin
      int  k  = int'($urandom_range(1, 0));
      int  r  = int'($urandom_range(15, 0));
      bit  we = $urandom_range(1, 0) == 1;
      adr = BASE | {23'h0, 7'($urandom), 2'($urandom)};
      dat = $urandom;
      if (r == 0) adr = adr ^ (32'h1 << $urandom_range(31, 9));
      xfer(k, we, 4'($urandom), adr, dat, (r == 1) ? 1 : 0);
    end

    // Final sweep: read back every word of both macros.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 128; i++)
        xfer(k, 1'b0, 4'h0, BASE + 32'(i * 4), 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
